tx_sched_arb: RTL

- Next-generation switch TX scheduler: merges FIFO read control, frame selection and switch-interface drive into one FSM-controlled block.
- Adds three features the current scheduler lacks:
  - selectable round-robin or fixed-priority arbitration;
  - full-FIFO urgency;
  - op_id generation with an outstanding-transaction limit fed back from the receive side.
- Sits between the per-switch request FIFOs and the switch memory interfaces.

---
 rtl/tx_sched_arb_pkg.sv | 33 +++
 rtl/tx_sched_arb_if.sv | 47 ++++
 rtl/tx_sched_arb_arbiter.sv | 37 +++
 rtl/tx_sched_arb.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/tx_sched_arb_pkg.sv
// Shared types and constants for the TX scheduler: FSM state, op_id width, frame field layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tx_sched_pkg;

    localparam int OP_ID_W = 8;

    // Frame layout: {ignored upper bits, wr_rd_s, addr, wr_data}
    localparam int FLD_WDAT_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        CAP   = 2'd2,
        ISSUE = 2'd3
    } state_t;

    // LSB of the address field for a given switch-interface width
    function automatic int fld_addr_lsb(input int w);
        return w;
    endfunction

    // Bit position of the write/read select for a given switch-interface width
    function automatic int fld_wr_bit(input int w);
        return 2 * w;
    endfunction

    // Channel index width, never below one bit so a single channel still compiles
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tx_sched_arb_if.sv
// Bundle of FIFO-side, switch-side and RX-feedback signals around the TX scheduler.
// Latency: n/a (wiring only).
// Backpressure: sw_busy/empty_in gate arbitration; outstanding limit gates grants.
interface tx_sched_arb_if #(
    parameter int NUM_SW_INST = 5,
    parameter int W_WIDTH     = 8,
    parameter int FRAME_WIDTH = 32,
    parameter int MAX_OUT     = 4
);
    import tx_sched_pkg::*;

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    // Environment -> scheduler
    logic                               mode;
    logic [NUM_SW_INST-1:0]             empty_in;
    logic [NUM_SW_INST-1:0]             full_in;
    logic [NUM_SW_INST-1:0]             sw_busy;
    logic [NUM_SW_INST*FRAME_WIDTH-1:0] frame_in;
    logic                               rsp_done;

    // Scheduler -> environment
    logic [NUM_SW_INST-1:0]             fifo_rd_en;
    logic [NUM_SW_INST-1:0]             sel_en;
    logic [W_WIDTH-1:0]                 addr;
    logic [W_WIDTH-1:0]                 wr_data;
    logic                               wr_rd_s;
    logic [OP_ID_W-1:0]                 op_id;
    logic                               issue_valid;
    logic [CNT_W-1:0]                   outstanding;
    logic                               err_underflow;

    // Scheduler side: drives FIFO pops and the switch bus
    modport master (
        input  mode, empty_in, full_in, sw_busy, frame_in, rsp_done,
        output fifo_rd_en, sel_en, addr, wr_data, wr_rd_s, op_id,
               issue_valid, outstanding, err_underflow
    );

    // FIFO / switch / RX side
    modport slave (
        output mode, empty_in, full_in, sw_busy, frame_in, rsp_done,
        input  fifo_rd_en, sel_en, addr, wr_data, wr_rd_s, op_id,
               issue_valid, outstanding, err_underflow
    );

endinterface

// File: rtl/tx_sched_arb_arbiter.sv
// Combinational channel picker: fixed priority (lowest index) or round-robin after a pointer.
// Latency: 0 cycles, pure combinational.
// Backpressure: none; an all-zero candidate vector simply yields no grant.
module sched_rr_arbiter #(
    parameter int N     = 5,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     i_cand,
    input  logic             i_mode,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_gnt_vld,
    output logic [N-1:0]     o_gnt_oh,
    output logic [IDX_W-1:0] o_gnt_idx
);

    // Pick the winner; loops run from the far end so the first match in search order overwrites last
    always_comb begin
        int w_c;
        w_c       = 0;
        o_gnt_vld = |i_cand;
        o_gnt_idx = '0;
        if (i_mode) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (i_cand[i]) o_gnt_idx = IDX_W'(i);
            end
        end else begin
            // Search order is ptr+1, ptr+2, ... wrapping, ending at ptr itself
            for (int k = N; k >= 1; k--) begin
                w_c = int'(i_ptr) + k;
                if (w_c >= N) w_c = w_c - N;
                if (i_cand[w_c]) o_gnt_idx = IDX_W'(w_c);
            end
        end
        o_gnt_oh = o_gnt_vld ? (N'(1) << o_gnt_idx) : '0;
    end

endmodule

// File: rtl/tx_sched_arb.sv
// TX scheduler: arbitrates FIFOs, pops the winner, captures its frame and issues it to the switch.
// Latency: grant at T, FIFO pop at T+1, frame capture at T+2, issue strobe at T+3; one issue per 4 cycles max.
// Backpressure: no grant while outstanding == MAX_OUT or no eligible channel; a grant always completes.
module tx_sched_arb
    import tx_sched_pkg::*;
#(
    parameter int NUM_SW_INST = 5,
    parameter int W_WIDTH     = 8,
    parameter int FRAME_WIDTH = 32,
    parameter int MAX_OUT     = 4
) (
    input logic           clk,
    input logic           rst,
    tx_sched_arb_if.master bus
);

    localparam int IDX_W    = idx_width(NUM_SW_INST);
    localparam int CNT_W    = $clog2(MAX_OUT + 1);
    localparam int ADDR_LSB = fld_addr_lsb(W_WIDTH);
    localparam int WR_BIT   = fld_wr_bit(W_WIDTH);

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [IDX_W-1:0]       r_win_idx;
    logic [NUM_SW_INST-1:0] r_win_oh;
    logic [IDX_W-1:0]       r_ptr;

    logic [W_WIDTH-1:0]     r_addr;
    logic [W_WIDTH-1:0]     r_wdat;
    logic                   r_wr;

    logic [OP_ID_W-1:0]     r_op_id;
    logic [CNT_W-1:0]       r_outstanding;
    logic                   r_err;

    logic [NUM_SW_INST-1:0] w_elig;
    logic [NUM_SW_INST-1:0] w_urg;
    logic [NUM_SW_INST-1:0] w_cand;
    logic                   w_gnt_vld;
    logic [NUM_SW_INST-1:0] w_gnt_oh;
    logic [IDX_W-1:0]       w_gnt_idx;
    logic                   w_grant;
    logic                   w_issue;

    logic [W_WIDTH-1:0]     w_frm_addr;
    logic [W_WIDTH-1:0]     w_frm_wdat;
    logic                   w_frm_wr;

    // Full FIFOs that could be served pre-empt everything else
    assign w_elig  = ~bus.empty_in & ~bus.sw_busy;
    assign w_urg   = w_elig & bus.full_in;
    assign w_cand  = (|w_urg) ? w_urg : w_elig;

    sched_rr_arbiter #(
        .N     (NUM_SW_INST),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_cand    (w_cand),
        .i_mode    (bus.mode),
        .i_ptr     (r_ptr),
        .o_gnt_vld (w_gnt_vld),
        .o_gnt_oh  (w_gnt_oh),
        .o_gnt_idx (w_gnt_idx)
    );

    assign w_grant = (r_state == IDLE) && w_gnt_vld && (r_outstanding < CNT_W'(MAX_OUT));
    assign w_issue = (r_state == ISSUE);

    // Select the winner's frame fields out of the flattened FIFO read bus
    always_comb begin
        w_frm_addr = '0;
        w_frm_wdat = '0;
        w_frm_wr   = 1'b0;
        for (int i = 0; i < NUM_SW_INST; i++) begin
            if (r_win_idx == IDX_W'(i)) begin
                w_frm_wdat = bus.frame_in[i*FRAME_WIDTH + FLD_WDAT_LSB +: W_WIDTH];
                w_frm_addr = bus.frame_in[i*FRAME_WIDTH + ADDR_LSB +: W_WIDTH];
                w_frm_wr   = bus.frame_in[i*FRAME_WIDTH + WR_BIT];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next state: once granted, the transaction runs to ISSUE regardless of inputs
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_grant) w_state_nxt = RD;
            RD:      w_state_nxt = CAP;
            CAP:     w_state_nxt = ISSUE;
            ISSUE:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs: FIFO pop only in RD, switch bus only in ISSUE, zero elsewhere
    always_comb begin
        bus.fifo_rd_en  = '0;
        bus.sel_en      = '0;
        bus.addr        = '0;
        bus.wr_data     = '0;
        bus.wr_rd_s     = 1'b0;
        bus.op_id       = '0;
        bus.issue_valid = 1'b0;
        case (r_state)
            RD: bus.fifo_rd_en = r_win_oh;
            ISSUE: begin
                bus.sel_en      = r_win_oh;
                bus.addr        = r_addr;
                bus.wr_data     = r_wdat;
                bus.wr_rd_s     = r_wr;
                bus.op_id       = r_op_id;
                bus.issue_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.outstanding   = r_outstanding;
    assign bus.err_underflow = r_err;

    // Winner latch, round-robin pointer and frame capture (FIFO data valid the cycle after the pop)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_idx <= '0;
            r_win_oh  <= '0;
            r_ptr     <= IDX_W'(NUM_SW_INST - 1);
            r_addr    <= '0;
            r_wdat    <= '0;
            r_wr      <= 1'b0;
        end else begin
            if (w_grant) begin
                r_win_idx <= w_gnt_idx;
                r_win_oh  <= w_gnt_oh;
                r_ptr     <= w_gnt_idx;
            end
            if (r_state == CAP) begin
                r_addr <= w_frm_addr;
                r_wdat <= w_frm_wdat;
                r_wr   <= w_frm_wr;
            end
        end
    end

    // op_id tag, outstanding count and sticky underflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_id       <= '0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else begin
            if (w_issue) r_op_id <= r_op_id + OP_ID_W'(1);
            // A response landing on the issue cycle cancels the increment
            if (w_issue && !bus.rsp_done) begin
                r_outstanding <= r_outstanding + CNT_W'(1);
            end else if (!w_issue && bus.rsp_done) begin
                if (r_outstanding != '0) r_outstanding <= r_outstanding - CNT_W'(1);
                else                     r_err         <= 1'b1;
            end
        end
    end

endmodule
